// File: rtl/sr_seq_pkg.sv
// Shared types and defaults for the SR latch command sequencer.
// Optional retry on verify failure is enabled with SR_SEQ_RETRY_EN.
package sr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } seq_state_t;

    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_RST = 1'b0;

    localparam int DEF_DB_CYCLES    = 4;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_CHK_CYCLES   = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and registered rising-edge pulse
// for one raw push-button input.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The level only moves after DB_CYCLES consecutive synced samples disagree with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            rise    <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns debounced set/reset button presses into exclusive, verified S/R pulses for an SR latch.
// Define SR_SEQ_RETRY_EN to allow one re-drive before a verify failure becomes sticky.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int CHK_CYCLES   = DEF_CHK_CYCLES
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    input  logic Q_fb,
    input  logic QBar_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic state_q,
    output logic err
);

    localparam int CW = $clog2(max2(PULSE_CYCLES, CHK_CYCLES) + 1);

    seq_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          tgt, tgt_d;
    logic          state_q_d, err_d;
    logic          pick;
    logic          set_rise, rst_rise;
    logic          set_pend, rst_pend;
    logic          set_clr, rst_clr;
    logic          q_s1, q_s2, qb_s1, qb_s2;
`ifdef SR_SEQ_RETRY_EN
    logic          retry, retry_d;
`endif

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk  (Clk),
        .rst_n(Rst_n),
        .btn  (set_btn),
        .rise (set_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
        .clk  (Clk),
        .rst_n(Rst_n),
        .btn  (rst_btn),
        .rise (rst_rise)
    );

    // A new edge wins over a same-cycle clear so a press during service is never lost.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            q_s1     <= 1'b0;
            q_s2     <= 1'b0;
            qb_s1    <= 1'b0;
            qb_s2    <= 1'b0;
            set_pend <= 1'b0;
            rst_pend <= 1'b0;
        end else begin
            q_s1     <= Q_fb;
            q_s2     <= q_s1;
            qb_s1    <= QBar_fb;
            qb_s2    <= qb_s1;
            set_pend <= set_rise | (set_pend & ~set_clr);
            rst_pend <= rst_rise | (rst_pend & ~rst_clr);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= CMD_RST;
            state_q <= 1'b0;
            err     <= 1'b0;
`ifdef SR_SEQ_RETRY_EN
            retry   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            tgt     <= tgt_d;
            state_q <= state_q_d;
            err     <= err_d;
`ifdef SR_SEQ_RETRY_EN
            retry   <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tgt_d     = tgt;
        state_q_d = state_q;
        err_d     = err;
        set_clr   = 1'b0;
        rst_clr   = 1'b0;
        pick      = rst_pend ? CMD_RST : CMD_SET;
`ifdef SR_SEQ_RETRY_EN
        retry_d   = retry;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (rst_pend || set_pend) begin
                    rst_clr = rst_pend;
                    set_clr = ~rst_pend;
                    // A request for the already-confirmed level is dropped unless a past verify failed.
                    if ((pick != state_q) || err) begin
                        state_d = DRIVE;
                        tgt_d   = pick;
                    end
                end
            end
            DRIVE: begin
                if (cnt == CW'(PULSE_CYCLES - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == CW'(CHK_CYCLES - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if ((q_s2 == tgt) && (qb_s2 == ~tgt)) begin
                    state_q_d = tgt;
                    state_d   = IDLE;
                end else begin
`ifdef SR_SEQ_RETRY_EN
                    if (!retry) begin
                        retry_d = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
`else
                    err_d   = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef SR_SEQ_RETRY_EN
        if (state_d == IDLE) begin
            retry_d = 1'b0;
        end
`endif
    end

    assign S    = (state == DRIVE) && (tgt == CMD_SET);
    assign R    = (state == DRIVE) && (tgt == CMD_RST);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed and randomized bench for sr_cmd_sequencer with an event-level reference model
// and a behavioural SR latch that can be forced stuck at Q=0.
module tb_sr_cmd_sequencer;
    import sr_seq_pkg::*;

    localparam int DB = DEF_DB_CYCLES;
    localparam int P  = DEF_PULSE_CYCLES;
    localparam int C  = DEF_CHK_CYCLES;
`ifdef SR_SEQ_RETRY_EN
    localparam int TRIES = 2;
`else
    localparam int TRIES = 1;
`endif

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic set_btn = 1'b0;
    logic rst_btn = 1'b0;
    logic Q_fb = 1'b0;
    logic QBar_fb = 1'b1;
    logic S, R, busy, state_q, err;

    int total = 0;
    int bad = 0;

    bit   stuck = 1'b0;
    logic latch_q = 1'b0;
    int   cyc = 0;

    int s_cycles, r_cycles, busy_cycles, first_s, first_r;

    // Reference model state, expressed as pending requests and command start times.
    int  set_run, rst_run, set_rise_at, rst_rise_at;
    bit  set_lvl, rst_lvl, sb1, sb2, rb1, rb2, q1, q2, qb1, qb2;
    bit  m_set_pend, m_rst_pend, m_active, m_tgt, m_state_q, m_err;
    int  m_start, m_tries;

    always #5 Clk = ~Clk;

    sr_cmd_sequencer dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .set_btn(set_btn),
        .rst_btn(rst_btn),
        .Q_fb   (Q_fb),
        .QBar_fb(QBar_fb),
        .S      (S),
        .R      (R),
        .busy   (busy),
        .state_q(state_q),
        .err    (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        {set_run, rst_run} = '0;
        set_rise_at = -1;
        rst_rise_at = -1;
        {set_lvl, rst_lvl, sb1, sb2, rb1, rb2, q1, q2, qb1, qb2} = '0;
        {m_set_pend, m_rst_pend, m_active, m_tgt, m_state_q, m_err} = '0;
        m_start = 0;
        m_tries = 0;
    endtask

    task automatic debounceModel(input bit s, inout bit lvl, inout int run, inout int rise_at);
        if (s != lvl) begin
            run++;
            if (run == DB) begin
                lvl = s;
                run = 0;
                if (s) rise_at = cyc + 2;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic modelEdge(input bit rn, input bit sb, input bit rb, input bit qf, input bit qbf);
        bit pick;
        if (!rn) begin
            modelReset();
            return;
        end
        if (!m_active) begin
            if (m_rst_pend || m_set_pend) begin
                pick = !m_rst_pend;
                if (m_rst_pend) m_rst_pend = 0; else m_set_pend = 0;
                if (pick != m_state_q || m_err) begin
                    m_active = 1;
                    m_tgt    = pick;
                    m_start  = cyc;
                    m_tries  = 1;
                end
            end
        end else if (cyc == m_start + P + C + 1) begin
            if (q2 == m_tgt && qb2 == !m_tgt) begin
                m_state_q = m_tgt;
                m_active  = 0;
            end else if (m_tries < TRIES) begin
                m_start = cyc;
                m_tries++;
            end else begin
                m_err    = 1;
                m_active = 0;
            end
        end
        if (set_rise_at == cyc) m_set_pend = 1;
        if (rst_rise_at == cyc) m_rst_pend = 1;
        debounceModel(sb2, set_lvl, set_run, set_rise_at);
        debounceModel(rb2, rst_lvl, rst_run, rst_rise_at);
        sb2 = sb1; sb1 = sb;
        rb2 = rb1; rb1 = rb;
        q2  = q1;  q1  = qf;
        qb2 = qb1; qb1 = qbf;
    endtask

    task automatic tick();
        bit in_drive;
        @(posedge Clk);
        cyc++;
        modelEdge(Rst_n, set_btn, rst_btn, Q_fb, QBar_fb);
        #1;
        in_drive = m_active && (cyc >= m_start) && (cyc < m_start + P);
        checkOutput("S", S, in_drive && m_tgt);
        checkOutput("R", R, in_drive && !m_tgt);
        checkOutput("S_and_R", S & R, 0);
        checkOutput("busy", busy, m_active);
        checkOutput("state_q", state_q, m_state_q);
        checkOutput("err", err, m_err);
        if (S === 1'b1) begin
            s_cycles++;
            if (first_s < 0) first_s = cyc;
        end
        if (R === 1'b1) begin
            r_cycles++;
            if (first_r < 0) first_r = cyc;
        end
        if (busy === 1'b1) busy_cycles++;
        if (S === 1'b1) latch_q = 1'b1;
        else if (R === 1'b1) latch_q = 1'b0;
        Q_fb    = stuck ? 1'b0 : latch_q;
        QBar_fb = stuck ? 1'b1 : ~latch_q;
    endtask

    task automatic clearCounts();
        s_cycles = 0;
        r_cycles = 0;
        busy_cycles = 0;
        first_s = -1;
        first_r = -1;
    endtask

    task automatic applyStimulus(input logic sb, input logic rb, input int n);
        set_btn = sb;
        rst_btn = rb;
        repeat (n) tick();
    endtask

    task automatic doReset(input int n);
        Rst_n = 1'b0;
        latch_q = 1'b0;
        applyStimulus(1'b0, 1'b0, n);
        Rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8);
        clearCounts();
    endtask

    initial begin
        int n_press;
        modelReset();
        clearCounts();

        $display("[TB] reset with both buttons held");
        Rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("t1_reset_quiet", s_cycles + r_cycles + busy_cycles, 0);
        Rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 15);
        applyStimulus(1'b0, 1'b0, 30);
        checkOutput("t1_no_r_pulse", r_cycles, 0);
        checkOutput("t1_set_pulse", s_cycles, P);
        checkOutput("t1_state_q", state_q, 1);

        $display("[TB] clean set press latency");
        doReset(2);
        n_press = cyc + 1;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("t2_first_s", first_s, n_press + DB + 4);
        checkOutput("t2_s_width", s_cycles, P);
        checkOutput("t2_busy_len", busy_cycles, P + C + 1);
        checkOutput("t2_r_never", r_cycles, 0);
        checkOutput("t2_state_q", state_q, 1);

        $display("[TB] short glitch");
        doReset(2);
        applyStimulus(1'b1, 1'b0, DB - 1);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("t3_no_s", s_cycles, 0);
        checkOutput("t3_no_busy", busy_cycles, 0);

        $display("[TB] simultaneous set and reset");
        doReset(2);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("t4_pre_state_q", state_q, 1);
        clearCounts();
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("t4_r_width", r_cycles, P);
        checkOutput("t4_s_width", s_cycles, P);
        checkOutput("t4_r_before_s", (first_r >= 0) && (first_r < first_s), 1);
        checkOutput("t4_state_q", state_q, 1);

        $display("[TB] stuck latch");
        doReset(2);
        stuck = 1'b1;
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 60);
        checkOutput("t5_s_pulses", s_cycles, P * TRIES);
        checkOutput("t5_err", err, 1);
        checkOutput("t5_state_q", state_q, 0);
        stuck = 1'b0;

        $display("[TB] reset during drive");
        doReset(2);
        set_btn = 1'b1;
        for (int i = 0; i < 30 && S !== 1'b1; i++) tick();
        checkOutput("t6_drive_seen", S, 1);
        Rst_n = 1'b0;
        set_btn = 1'b0;
        tick();
        checkOutput("t6_s_dropped", S, 0);
        checkOutput("t6_busy_dropped", busy, 0);
        Rst_n = 1'b1;
        clearCounts();
        applyStimulus(1'b0, 1'b0, 30);
        checkOutput("t6_no_more_s", s_cycles, 0);
        checkOutput("t6_no_check", state_q, 0);

        $display("[TB] randomized traffic");
        doReset(2);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) stuck = ~stuck;
            Rst_n = ($urandom_range(0, 39) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        Rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
